// File: rtl/conversor_inv_seq.sv
// rtl/conversor_inv_seq.sv - registered digit-to-HGFE converter with 2-word output buffer (optional err_cnt: CONVERSOR_ERRCNT_EN)
module conversor_inv_seq #(
    parameter int         CNT_W    = 8,
    parameter logic [3:0] ERR_CODE = 4'b1111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       digit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       code,
    output logic             code_err,
    output logic [CNT_W-1:0] conv_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [4:0]       head_q;
    logic [4:0]       tail_q;
    logic [CNT_W-1:0] conv_cnt_q;

    logic             accept;
    logic             drain;
    logic [4:0]       new_word;

    // Entry layout is {code[3:0], code_err}.
    function automatic logic [4:0] encode(input logic [3:0] d);
        logic [4:0] w;
        case (d)
            4'd0:    w = {4'b0000, 1'b0};
            4'd1:    w = {4'b0001, 1'b0};
            4'd2:    w = {4'b0011, 1'b0};
            4'd3:    w = {4'b0100, 1'b0};
            4'd4:    w = {4'b0101, 1'b0};
            4'd5:    w = {4'b0111, 1'b0};
            4'd6:    w = {4'b1001, 1'b0};
            4'd7:    w = {4'b1011, 1'b0};
            4'd8:    w = {4'b1100, 1'b0};
            4'd9:    w = {4'b1101, 1'b0};
            default: w = {ERR_CODE, 1'b1};
        endcase
        return w;
    endfunction

    assign accept   = in_valid && in_ready_q;
    assign drain    = out_valid_q && out_ready;
    assign new_word = encode(digit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_q      <= 5'd0;
            tail_q      <= 5'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        head_q      <= new_word;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head_q <= new_word;
                    end else if (accept) begin
                        tail_q     <= new_word;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (drain) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (drain) begin
                        head_q     <= tail_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_cnt_q <= '0;
        end else if (accept && (conv_cnt_q != {CNT_W{1'b1}})) begin
            conv_cnt_q <= conv_cnt_q + CNT_W'(1);
        end
    end

`ifdef CONVERSOR_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (accept && new_word[0] && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign code      = head_q[4:1];
    assign code_err  = head_q[0];
    assign conv_cnt  = conv_cnt_q;

endmodule

// File: tb/tb_conversor_inv_seq.sv
// tb/tb_conversor_inv_seq.sv - randomized bench for conversor_inv_seq against a queue model
module tb_conversor_inv_seq;

    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       digit;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       code;
    logic             code_err;
    logic [CNT_W-1:0] conv_cnt;
    logic [CNT_W-1:0] err_cnt;

    conversor_inv_seq #(.CNT_W(CNT_W), .ERR_CODE(4'b1111)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .digit     (digit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .code_err  (code_err),
        .conv_cnt  (conv_cnt),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [3:0] hgfe_tbl [10] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd12, 4'd13};

    logic [4:0] mq [$];
    bit         rdy_m;
    int         conv_m;
    int         err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] ref_word(input logic [3:0] d);
        if (d > 4'd9) return {4'b1111, 1'b1};
        return {hgfe_tbl[d], 1'b0};
    endfunction

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(rdy_m));
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("code", 32'(code), 32'(mq[0][4:1]));
            check("code_err", 32'(code_err), 32'(mq[0][0]));
        end
        check("conv_cnt", 32'(conv_cnt), 32'(conv_m));
`ifdef CONVERSOR_ERRCNT_EN
        check("err_cnt", 32'(err_cnt), 32'(err_m));
`else
        check("err_cnt", 32'(err_cnt), 32'd0);
`endif
    endtask

    // One clock: check at negedge, drive, then advance the model across the posedge.
    task automatic cycle(input bit rst, input bit v, input logic [3:0] d, input bit ordy);
        bit acc;
        bit drn;
        check_outputs();
        rst_n     = rst;
        in_valid  = v;
        digit     = d;
        out_ready = ordy;
        acc = rst && v && rdy_m;
        drn = rst && (mq.size() > 0) && ordy;
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            rdy_m  = 1'b0;
            conv_m = 0;
            err_m  = 0;
        end else begin
            if (drn) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(ref_word(d));
                if (conv_m < CMAX) conv_m++;
                if (d > 4'd9 && err_m < CMAX) err_m++;
            end
            rdy_m = (mq.size() < 2);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; digit = 4'd0; out_ready = 1'b0;
        rdy_m = 1'b0; conv_m = 0; err_m = 0;
        @(posedge clk);
        @(negedge clk);
        check("reset_code", 32'(code), 32'd0);
        check("reset_code_err", 32'(code_err), 32'd0);

        // Back-to-back legal digits
        cycle(1, 0, 4'd0, 1);
        for (int i = 0; i < 10; i++) cycle(1, 1, 4'(i), 1);
        cycle(1, 0, 4'd0, 1);
        check("conv_after_ten", 32'(conv_cnt), 32'd10);
        cycle(1, 0, 4'd0, 1);

        // Stall: 3,7 fill the buffer, 2 waits
        cycle(1, 1, 4'd3, 0);
        cycle(1, 1, 4'd7, 0);
        cycle(1, 1, 4'd2, 0);
        cycle(1, 1, 4'd2, 0);
        for (int i = 0; i < 4; i++) cycle(1, (i == 0), 4'd2, 1);

        // Simultaneous accept and drain in ONE
        cycle(1, 1, 4'd5, 0);
        cycle(1, 1, 4'd8, 1);
        cycle(1, 0, 4'd0, 0);
        cycle(1, 0, 4'd0, 1);

        // Illegal digits
        cycle(1, 1, 4'd10, 1);
        cycle(1, 1, 4'd15, 1);
        cycle(1, 0, 4'd0, 1);
        cycle(1, 0, 4'd0, 1);

        // Reset while full, then first digit after release
        cycle(1, 1, 4'd1, 0);
        cycle(1, 1, 4'd4, 0);
        cycle(0, 1, 4'd6, 0);
        check("midrst_code", 32'(code), 32'd0);
        cycle(1, 1, 4'd9, 1);
        cycle(1, 1, 4'd9, 1);
        cycle(1, 0, 4'd0, 1);

        // Counter saturation
        cycle(0, 0, 4'd0, 1);
        cycle(1, 0, 4'd0, 1);
        for (int i = 0; i < 20; i++) cycle(1, 1, 4'($urandom_range(0, 15)), 1);
        cycle(1, 0, 4'd0, 1);
        check("conv_saturated", 32'(conv_cnt), 32'd15);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
        cycle(1, 0, 4'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conversor_inv_seq.md
Name: conversor_inv_seq

Overview:
- Registered inverse of the 4-bit code converter.
- Accepts a binary decimal digit (0..9) on a valid/ready input and emits the matching 4-bit HGFE code word on a valid/ready output.
- Buffers up to 2 words so the upstream can keep streaming while downstream stalls.
- Sits between the digit source (counters, keypad logic) and any consumer of the HGFE code; the output feeds the existing conversor for loop-back checks.

Parameters:
- CNT_W, 8, width of the converted-digit counter and error counter (saturating).
- ERR_CODE, 4'b1111, code word emitted for an out-of-range digit (not a legal HGFE code).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  digit presented.
- in_ready  output  1  block can accept a digit this cycle.
- digit  input  4  binary digit {D,C,B,A}; legal 0..9.
- out_valid  output  1  code word available.
- out_ready  input  1  consumer accepts the code word this cycle.
- code  output  4  {H,G,F,E} code word.
- code_err  output  1  qualifies code: 1 = word came from an illegal digit (10..15).
- conv_cnt  output  CNT_W  number of words accepted since reset, saturating at all-ones.
- err_cnt  output  CNT_W  illegal digits accepted; present only with the optional feature, else tied 0.

Behaviour:
- Mapping, digit -> code:
  - 0->0000, 1->0001, 2->0011, 3->0100, 4->0101
  - 5->0111, 6->1001, 7->1011, 8->1100, 9->1101
  - 10..15 -> ERR_CODE with code_err=1.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid, code and code_err hold stable until the output transfer; no combinational path from in_* to out_*.
- Storage: 2-entry FIFO of {code, code_err} (5 bits per entry); occupancy FSM with states EMPTY, ONE, FULL.
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept only -> FULL.
    - Drain only -> EMPTY.
    - Accept and drain in the same cycle -> stays ONE; the new word becomes head.
  - FULL: in_ready=0, out_valid=1. Drain -> ONE; in_valid is ignored.
- Latency:
  - Digit accepted at edge N -> code visible with out_valid=1 after edge N, i.e. 1 cycle.
  - Throughput 1 word/cycle while out_ready=1.
- Ordering: strictly FIFO; the head is always the oldest word.
- conv_cnt: +1 on every input transfer (legal or illegal); saturates at 2^CNT_W-1 and never wraps.
- Reset (rst_n=0 at an edge):
  - state=EMPTY, in_ready=0 during reset, out_valid=0, code=0000, code_err=0, conv_cnt=0, err_cnt=0.
  - Applies mid-stream too: buffered words are discarded with no partial output.
  - in_ready returns to 1 on the first edge after rst_n=1.
- X/illegal: an in_valid=0 digit value is don't-care and must not change state.

Optional Feature:
- Macro CONVERSOR_ERRCNT_EN.
- Defined: err_cnt increments on each input transfer with digit>9, saturating at 2^CNT_W-1.
- Undefined: err_cnt is constant 0, with no counter flops. code_err is present in both builds.

Test Plan:
- Reset then stream digits 0..9 back-to-back with out_ready=1 -> codes 0000,0001,0011,0100,0101,0111,1001,1011,1100,1101 on consecutive cycles, each one cycle after acceptance, code_err=0; conv_cnt=10.
- out_ready=0, push digits 3,7,2 -> first two accepted (state FULL, in_ready=0), 2 stalled. Raise out_ready -> outputs 0100, 1011, then 0011, in order.
- State ONE with digit 5 buffered; same cycle in_valid (digit 8) and out_ready=1 -> 0111 drains; next cycle head=1100, still ONE.
- Digits 10 and 15 -> code=1111, code_err=1 for each; err_cnt=2 with CONVERSOR_ERRCNT_EN, 0 without.
- FULL with 2 words, assert rst_n=0 for one edge -> out_valid=0, code=0000, counters 0; first digit after release (9) -> 1101 after 1 cycle.
- CNT_W=4: push 20 digits -> conv_cnt stops at 15 and does not wrap.
